// File: rtl/des_key_schedule_seq.sv
// -----------------------------------------------------------------------------
// des_key_schedule_seq
// Sequential DES key schedule. Takes a post-PC-1 key word C0||D0, then emits
// the sixteen PC-2 round subkeys one per accepted handshake, in encrypt order
// (K1..K16) or decrypt order (K16..K1).
//
// Ports
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset
//   key          : C0||D0, key[55] = C bit 1, key[0] = D bit 28
//   load         : start request, accepted only while ready=1
//   decrypt      : sampled with load; 1 = emit K16..K1
//   ready        : idle, load can be accepted
//   subkey       : current subkey, subkey[47] = PC-2 output bit 1
//   subkey_valid : subkey is valid
//   subkey_ack   : consumer takes the subkey this cycle
//   round        : 0-based emission index of the subkey
//   done         : pulse on the cycle the last subkey is accepted
// -----------------------------------------------------------------------------
module des_key_schedule_seq #(
   parameter int unsigned KEY_W  = 56,
   parameter int unsigned SK_W   = 48,
   parameter int unsigned ROUNDS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [KEY_W-1:0]  key,
   input  logic              load,
   input  logic              decrypt,
   output logic              ready,
   output logic [SK_W-1:0]   subkey,
   output logic              subkey_valid,
   input  logic              subkey_ack,
   output logic [3:0]        round,
   output logic              done
);

   localparam int unsigned HALF_W = KEY_W / 2;
   localparam int unsigned RND_W  = $clog2(ROUNDS);
   localparam int unsigned KI_W   = $clog2(KEY_W);
   localparam int unsigned SI_W   = $clog2(SK_W);

   // Bit n of this mask is set when the shift for 0-based round n is 2.
   localparam logic [ROUNDS-1:0] SHIFT2 = ROUNDS'(16'h7EFC);

   localparam int unsigned PC2 [SK_W] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EMIT = 1'b1} state_e;

   // Rotate one half left / right by 1 (two=0) or 2 (two=1).
   function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic two);
      return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
   endfunction

   function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic two);
      return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
   endfunction

   // PC-2 with FIPS 1-based numbering mapped onto MSB-first vectors.
   function automatic logic [SK_W-1:0] pc2(input logic [KEY_W-1:0] cd);
      logic [SK_W-1:0] k;
      k = '0;
      for (int j = 0; j < int'(SK_W); j++) begin
         k[SI_W'(int'(SK_W) - 1 - j)] = cd[KI_W'(KEY_W - PC2[j])];
      end
      return k;
   endfunction

   state_e             state_q, state_d;
   logic [HALF_W-1:0]  c_q, c_d, d_q, d_d;
   logic               dec_q, dec_d;
   logic [RND_W-1:0]   round_q, round_d;
   logic               valid_q, valid_d;
   logic               ready_q, ready_d;
   logic [SK_W-1:0]    subkey_q, subkey_d;
   logic [RND_W-1:0]   nidx;
   logic               two;
   logic               last;

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         c_q      <= '0;
         d_q      <= '0;
         dec_q    <= 1'b0;
         round_q  <= '0;
         valid_q  <= 1'b0;
         ready_q  <= 1'b1;
         subkey_q <= '0;
      end else begin
         state_q  <= state_d;
         c_q      <= c_d;
         d_q      <= d_d;
         dec_q    <= dec_d;
         round_q  <= round_d;
         valid_q  <= valid_d;
         ready_q  <= ready_d;
         subkey_q <= subkey_d;
      end
   end

   // Next-state: load C/D, then rotate on each accepted non-final subkey.
   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      dec_d   = dec_q;
      round_d = round_q;
      valid_d = valid_q;
      ready_d = ready_q;
      // Decrypt undoes the shift of the key just emitted (index 15-round).
      nidx    = dec_q ? ~round_q : round_q + RND_W'(1);
      two     = SHIFT2[nidx];
      last    = (round_q == RND_W'(ROUNDS - 1));

      case (state_q)
         ST_IDLE: begin
            ready_d = 1'b1;
            valid_d = 1'b0;
            if (load) begin
               dec_d   = decrypt;
               // Encrypt starts at C1D1 (shift 1); decrypt starts at C16D16 = C0D0.
               c_d     = decrypt ? key[KEY_W-1:HALF_W] : rotl(key[KEY_W-1:HALF_W], 1'b0);
               d_d     = decrypt ? key[HALF_W-1:0]     : rotl(key[HALF_W-1:0], 1'b0);
               round_d = '0;
               valid_d = 1'b1;
               ready_d = 1'b0;
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (subkey_ack) begin
               if (last) begin
                  round_d = '0;
                  valid_d = 1'b0;
                  ready_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  round_d = round_q + RND_W'(1);
                  c_d     = dec_q ? rotr(c_q, two) : rotl(c_q, two);
                  d_d     = dec_q ? rotr(d_q, two) : rotl(d_q, two);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      subkey_d = pc2({c_d, d_d});
   end

   // done coincides with the final handshake; a reset in that cycle suppresses it.
   assign done         = (state_q == ST_EMIT) && subkey_ack && last && !rst;
   assign ready        = ready_q;
   assign subkey_valid = valid_q;
   assign subkey       = subkey_q;
   assign round        = 4'(round_q);

endmodule
